// File: rtl/sauria_demo_pkg.sv
// sauria_demo_pkg: shared types and default parameters
// for the SAURIA config sequencer.
package sauria_demo_pkg;

  localparam int DefAddrWidth     = 32;
  localparam int DefDataWidth     = 32;
  localparam int DefNumEntries    = 16;
  localparam int DefNumCtx        = 2;
  localparam int DefVerifyEn      = 1;
  localparam int DefTimeoutCycles = 1024;

  typedef struct packed {
    logic [DefAddrWidth-1:0] addr;
    logic [DefDataWidth-1:0] data;
  } cfg_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RWAIT,
    S_DONE,
    S_ERR
  } seq_state_e;

endpackage

// File: rtl/sauria_cfg_table.sv
// sauria_cfg_table: per-context (addr, data) entry store,
// one synchronous write port, one combinational read port.
module sauria_cfg_table
  import sauria_demo_pkg::*;
#(
  parameter int AddrWidth = DefAddrWidth,
  parameter int DataWidth = DefDataWidth,
  parameter int CtxW      = 1,
  parameter int IdxW      = 4
) (
  input  logic                 i_clk,
  input  logic                 i_we,
  input  logic [CtxW-1:0]      i_wctx,
  input  logic [IdxW-1:0]      i_widx,
  input  logic [AddrWidth-1:0] i_waddr,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [CtxW-1:0]      i_rctx,
  input  logic [IdxW-1:0]      i_ridx,
  output logic [AddrWidth-1:0] o_raddr,
  output logic [DataWidth-1:0] o_rdata
);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data;
  } entry_t;

  localparam int Depth = 2 ** (CtxW + IdxW);

  entry_t r_mem [Depth];
  entry_t w_rd;

  // Table write; contents deliberately carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{i_wctx, i_widx}] <= '{addr: i_waddr, data: i_wdata};
    end
  end

  assign w_rd    = r_mem[{i_rctx, i_ridx}];
  assign o_raddr = w_rd.addr;
  assign o_rdata = w_rd.data;

endmodule

// File: rtl/sauria_cfg_sequencer.sv
// sauria_cfg_sequencer: replays one context of register
// writes (optional read-back) onto the SAURIA cfg port.
module sauria_cfg_sequencer
  import sauria_demo_pkg::*;
#(
  parameter int AddrWidth     = DefAddrWidth,
  parameter int DataWidth     = DefDataWidth,
  parameter int NumEntries    = DefNumEntries,
  parameter int NumCtx        = DefNumCtx,
  parameter int VerifyEn      = DefVerifyEn,
  parameter int TimeoutCycles = DefTimeoutCycles,
  localparam int CtxW = (NumCtx > 1) ? $clog2(NumCtx) : 1,
  localparam int IdxW = $clog2(NumEntries),
  localparam int LenW = IdxW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tbl_we_i,
  input  logic [CtxW-1:0]      tbl_ctx_i,
  input  logic [IdxW-1:0]      tbl_idx_i,
  input  logic [AddrWidth-1:0] tbl_addr_i,
  input  logic [DataWidth-1:0] tbl_data_i,
  input  logic                 start_i,
  input  logic [CtxW-1:0]      ctx_i,
  input  logic [LenW-1:0]      len_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [IdxW-1:0]      err_idx_o
);

  localparam int TW = $clog2(TimeoutCycles + 1);

  seq_state_e      r_state;
  logic [CtxW-1:0] r_ctx;
  logic [LenW-1:0] r_len;
  logic [IdxW-1:0] r_idx;
  logic [TW-1:0]   r_tcnt;
  logic            r_req;
  logic            r_we;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [IdxW-1:0] r_err_idx;

  logic                 w_tbl_we;
  logic [AddrWidth-1:0] w_addr;
  logic [DataWidth-1:0] w_data;
  logic [LenW-1:0]      w_len;
  logic                 w_last;
  logic                 w_tmo;

  assign w_tbl_we = tbl_we_i && !r_busy;
  assign w_len    = (len_i > LenW'(NumEntries)) ? LenW'(NumEntries) : len_i;
  assign w_last   = ({1'b0, r_idx} + LenW'(1)) == r_len;
  assign w_tmo    = r_tcnt == TW'(TimeoutCycles - 1);

  sauria_cfg_table #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .CtxW     (CtxW),
    .IdxW     (IdxW)
  ) u_table (
    .i_clk  (clk_i),
    .i_we   (w_tbl_we),
    .i_wctx (tbl_ctx_i),
    .i_widx (tbl_idx_i),
    .i_waddr(tbl_addr_i),
    .i_wdata(tbl_data_i),
    .i_rctx (r_ctx),
    .i_ridx (r_idx),
    .o_raddr(w_addr),
    .o_rdata(w_data)
  );

  // Sequencer FSM with index/timeout counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_ctx     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_tcnt    <= '0;
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
    end else begin
      r_done <= 1'b0;
      r_tcnt <= r_tcnt + TW'(1);
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_ctx  <= ctx_i;
            r_len  <= w_len;
            r_idx  <= '0;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_tcnt <= '0;
            if (w_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WR;
              r_req   <= 1'b1;
              r_we    <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (gnt_i) begin
            r_tcnt <= '0;
            if (VerifyEn != 0) begin
              r_state <= S_RD;
              r_we    <= 1'b0;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_req   <= 1'b0;
              r_we    <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + IdxW'(1);
            end
          end else if (w_tmo) begin
            r_state   <= S_ERR;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end
        end
        S_RD: begin
          if (gnt_i) begin
            r_tcnt  <= '0;
            r_state <= S_RWAIT;
            r_req   <= 1'b0;
          end else if (w_tmo) begin
            r_state   <= S_ERR;
            r_req     <= 1'b0;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end
        end
        S_RWAIT: begin
          if (rvalid_i) begin
            r_tcnt <= '0;
            if (rdata_i != w_data) begin
              r_state   <= S_ERR;
              r_err     <= 1'b1;
              r_err_idx <= r_idx;
            end else if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WR;
              r_idx   <= r_idx + IdxW'(1);
              r_req   <= 1'b1;
              r_we    <= 1'b1;
            end
          end else if (w_tmo) begin
            r_state   <= S_ERR;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_o     = r_req;
  assign we_o      = r_we;
  assign addr_o    = w_addr;
  assign wdata_o   = w_data;
  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// tb_sauria_cfg_sequencer: randomized bench for the config
// sequencer, one instance without and one with read-back.
module tb_sauria_cfg_sequencer;
  import sauria_demo_pkg::*;

  localparam int TO = 8;
  localparam int NE = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  logic tbl_we;
  logic [0:0] tbl_ctx;
  logic [3:0] tbl_idx;
  logic [31:0] tbl_addr, tbl_data;
  logic sel, start;
  logic [0:0] ctx;
  logic [4:0] len;
  logic gnt, rvalid;
  logic [31:0] rdata;

  logic n_req, n_we, n_busy, n_done, n_err;
  logic [31:0] n_addr, n_wdata;
  logic [3:0] n_eidx;
  logic v_req, v_we, v_busy, v_done, v_err;
  logic [31:0] v_addr, v_wdata;
  logic [3:0] v_eidx;

  logic o_req, o_we, o_busy, o_done, o_err;
  logic [31:0] o_addr, o_wdata;
  logic [3:0] o_eidx;

  assign o_req   = sel ? v_req   : n_req;
  assign o_we    = sel ? v_we    : n_we;
  assign o_busy  = sel ? v_busy  : n_busy;
  assign o_done  = sel ? v_done  : n_done;
  assign o_err   = sel ? v_err   : n_err;
  assign o_addr  = sel ? v_addr  : n_addr;
  assign o_wdata = sel ? v_wdata : n_wdata;
  assign o_eidx  = sel ? v_eidx  : n_eidx;

  always #5 clk = ~clk;

  sauria_cfg_sequencer #(.VerifyEn(0), .TimeoutCycles(TO)) dut_n (
    .clk_i(clk), .rst_i(rst),
    .tbl_we_i(tbl_we), .tbl_ctx_i(tbl_ctx), .tbl_idx_i(tbl_idx),
    .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
    .start_i(start && !sel), .ctx_i(ctx), .len_i(len),
    .req_o(n_req), .we_o(n_we), .addr_o(n_addr), .wdata_o(n_wdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
    .busy_o(n_busy), .done_o(n_done), .err_o(n_err), .err_idx_o(n_eidx)
  );

  sauria_cfg_sequencer #(.VerifyEn(1), .TimeoutCycles(TO)) dut_v (
    .clk_i(clk), .rst_i(rst),
    .tbl_we_i(tbl_we), .tbl_ctx_i(tbl_ctx), .tbl_idx_i(tbl_idx),
    .tbl_addr_i(tbl_addr), .tbl_data_i(tbl_data),
    .start_i(start && sel), .ctx_i(ctx), .len_i(len),
    .req_o(v_req), .we_o(v_we), .addr_o(v_addr), .wdata_o(v_wdata),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata),
    .busy_o(v_busy), .done_o(v_done), .err_o(v_err), .err_idx_o(v_eidx)
  );

  int n_vec = 0;
  int n_bad = 0;

  cfg_entry_t m_tab [2][NE];
  logic [31:0] smem [logic [31:0]];

  txn_t obs_q[$];
  int   obs_cyc[$];
  int   r_ndone, r_dcyc, r_reqc, r_unst;
  bit   r_hung;
  logic r_err;
  logic [3:0] r_eidx;

  txn_t exp_q[$];
  bit   e_done, e_err;
  int   e_idx, e_cyc;

  // Reference: transactions and outcome derived from the table contents.
  function automatic void build_exp(input bit v, input int c, input int l,
                                    input int g, input int bad);
    int n;
    n = (l > NE) ? NE : l;
    exp_q.delete();
    e_err = 0; e_idx = 0;
    if (n > 0 && g >= TO) begin
      e_err = 1;
    end else begin
      for (int e = 0; e < n; e++) begin
        exp_q.push_back(txn_t'({1'b1, m_tab[c][e].addr, m_tab[c][e].data}));
        if (v) exp_q.push_back(txn_t'({1'b0, m_tab[c][e].addr, m_tab[c][e].data}));
        if (v && e == bad) begin
          e_err = 1; e_idx = e;
          break;
        end
      end
    end
    e_done = !e_err;
    e_cyc  = v ? n * (2 * g + 3) : n * (g + 1);
  endfunction

  // Slave model: grants after g waiting cycles, rvalid one cycle later.
  task automatic run_seq(input bit s, input int c, input int l, input int g,
                         input int bad, input bit nogrant, input int budget);
    int w, rdn, cyc;
    bit rvp, held;
    logic [31:0] la, ld, ra;
    obs_q.delete(); obs_cyc.delete();
    r_ndone = 0; r_dcyc = -1; r_reqc = 0; r_unst = 0; r_hung = 0;
    w = 0; rdn = 0; rvp = 0; held = 0; la = '0; ld = '0; ra = '0;
    @(negedge clk);
    sel = s; ctx = 1'(c); len = 5'(l); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 0; cyc < budget; cyc++) begin
      gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      if (o_done) begin r_ndone++; r_dcyc = cyc; end
      if (!o_busy) break;
      if (rvp) begin
        rvalid = 1'b1;
        rdata = (rdn - 1 == bad) ? 32'hDEAD :
                (smem.exists(ra) ? smem[ra] : 32'h0);
        rvp = 0;
      end
      if (o_req) begin
        r_reqc++;
        if (held && (o_addr !== la || o_wdata !== ld)) r_unst++;
        w++;
        if (!nogrant && w > g) begin
          gnt = 1'b1; w = 0; held = 0;
          obs_q.push_back(txn_t'({o_we, o_addr, o_wdata}));
          obs_cyc.push_back(cyc);
          if (o_we) smem[o_addr] = o_wdata;
          else begin rvp = 1; rdn++; ra = o_addr; end
        end else begin
          held = 1; la = o_addr; ld = o_wdata;
        end
      end else begin
        held = 0;
      end
      @(negedge clk);
    end
    r_hung = (cyc >= budget);
    gnt = 1'b0; rvalid = 1'b0;
    r_err = o_err; r_eidx = o_eidx;
  endtask

  task automatic load(input int c, input int i, input logic [31:0] a,
                      input logic [31:0] d);
    @(negedge clk);
    tbl_we = 1'b1; tbl_ctx = 1'(c); tbl_idx = 4'(i);
    tbl_addr = a; tbl_data = d;
    @(negedge clk);
    tbl_we = 1'b0;
    m_tab[c][i] = '{addr: a, data: d};
  endtask

  task automatic test_reset();
    n_vec++;
    if ({n_req, n_we, n_busy, n_done, n_err, n_eidx} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_n got %b exp 0", {n_req, n_we, n_busy, n_done, n_err, n_eidx});
    end
    n_vec++;
    if ({v_req, v_we, v_busy, v_done, v_err, v_eidx} !== 9'h0) begin
      n_bad++;
      $display("FAIL reset_v got %b exp 0", {v_req, v_we, v_busy, v_done, v_err, v_eidx});
    end
  endtask

  task automatic test_load();
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < NE; i++)
        load(c, i, $urandom & 32'hFFFF_FFFC, $urandom | 32'h0001_0000);
    load(0, 0, 32'h10, 32'hA);
    load(0, 1, 32'h14, 32'hB);
    load(0, 2, 32'h18, 32'hC);
  endtask

  task automatic test_t1_writes();
    run_seq(0, 0, 3, 0, -1, 0, 100);
    build_exp(0, 0, 3, 0, -1);
    n_vec++;
    if (obs_q.size() !== 3) begin n_bad++; $display("FAIL t1_count got %0d exp 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i] || obs_cyc[i] !== i) begin
        n_bad++;
        $display("FAIL t1_txn%0d got %h@%0d exp %h@%0d", i, obs_q[i], obs_cyc[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (r_ndone !== 1 || r_dcyc !== 3 || r_err !== 1'b0 || r_hung) begin
      n_bad++;
      $display("FAIL t1_done got n=%0d cyc=%0d err=%b exp n=1 cyc=3 err=0", r_ndone, r_dcyc, r_err);
    end
  endtask

  task automatic test_t2_verify();
    run_seq(1, 0, 3, 2, -1, 0, 200);
    build_exp(1, 0, 3, 2, -1);
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++; $display("FAIL t2_count got %0d exp %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t2_txn%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (r_ndone !== 1 || r_dcyc !== e_cyc || r_err !== 1'b0 || r_unst !== 0 || r_hung) begin
      n_bad++;
      $display("FAIL t2_done got n=%0d cyc=%0d err=%b unst=%0d exp n=1 cyc=%0d err=0 unst=0",
               r_ndone, r_dcyc, r_err, r_unst, e_cyc);
    end
  endtask

  task automatic test_t3_mismatch();
    run_seq(1, 0, 3, 0, 1, 0, 200);
    build_exp(1, 0, 3, 0, 1);
    n_vec++;
    if (obs_q.size() !== 4) begin n_bad++; $display("FAIL t3_count got %0d exp 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t3_txn%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_vec++;
    if (r_ndone !== 0 || r_err !== 1'b1 || r_eidx !== 4'd1 || r_hung) begin
      n_bad++;
      $display("FAIL t3_err got n=%0d err=%b idx=%0d exp n=0 err=1 idx=1", r_ndone, r_err, r_eidx);
    end
  endtask

  task automatic test_err_clear();
    run_seq(1, 1, 2, 0, -1, 0, 200);
    n_vec++;
    if (r_err !== 1'b0 || r_ndone !== 1 || r_hung) begin
      n_bad++; $display("FAIL err_clear got err=%b n=%0d exp err=0 n=1", r_err, r_ndone);
    end
  endtask

  task automatic test_t4_timeout();
    run_seq(0, 0, 3, 0, -1, 1, 100);
    n_vec++;
    if (r_reqc !== TO || r_err !== 1'b1 || r_eidx !== 4'd0 || r_ndone !== 0 || r_hung) begin
      n_bad++;
      $display("FAIL t4_timeout got req=%0d err=%b idx=%0d n=%0d exp req=%0d err=1 idx=0 n=0",
               r_reqc, r_err, r_eidx, r_ndone, TO);
    end
  endtask

  task automatic test_gnt_vs_timeout();
    run_seq(0, 1, 2, TO - 1, -1, 0, 100);
    build_exp(0, 1, 2, TO - 1, -1);
    n_vec++;
    if (r_ndone !== 1 || r_err !== 1'b0 || r_dcyc !== e_cyc || obs_q.size() !== 2) begin
      n_bad++;
      $display("FAIL gnt_wins got n=%0d err=%b cyc=%0d cnt=%0d exp n=1 err=0 cyc=%0d cnt=2",
               r_ndone, r_err, r_dcyc, obs_q.size(), e_cyc);
    end
  endtask

  task automatic test_t5_len();
    run_seq(1, 0, 0, 0, -1, 0, 50);
    n_vec++;
    if (r_ndone !== 1 || r_dcyc !== 0 || r_reqc !== 0 || r_err !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_len0 got n=%0d cyc=%0d req=%0d exp n=1 cyc=0 req=0", r_ndone, r_dcyc, r_reqc);
    end
    run_seq(0, 1, 20, 0, -1, 0, 100);
    build_exp(0, 1, 20, 0, -1);
    n_vec++;
    if (obs_q.size() !== NE || r_dcyc !== NE || r_ndone !== 1) begin
      n_bad++;
      $display("FAIL t5_len20 got cnt=%0d cyc=%0d exp cnt=%0d cyc=%0d", obs_q.size(), r_dcyc, NE, NE);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t5_txn%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_t6_reset();
    int ng, k;
    bit hit;
    @(negedge clk);
    sel = 1'b0; ctx = 1'b1; len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; ng = 0; hit = 0;
    for (k = 0; k < 20 && !hit; k++) begin
      gnt = 1'b0;
      if (o_req && ng == 2) begin
        n_vec++;
        if (o_addr !== m_tab[1][2].addr) begin
          n_bad++; $display("FAIL t6_entry2 got %h exp %h", o_addr, m_tab[1][2].addr);
        end
        rst = 1'b1; hit = 1;
      end else if (o_req) begin
        gnt = 1'b1; ng++;
      end
      @(negedge clk);
    end
    gnt = 1'b0;
    n_vec++;
    if (!hit || {o_req, o_busy, o_done, o_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL t6_abort got hit=%0d req/busy/done/err=%b exp 1 0000", hit, {o_req, o_busy, o_done, o_err});
    end
    rst = 1'b0;
    @(negedge clk);
    ctx = 1'b1; len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1) begin n_bad++; $display("FAIL t6_busy got %b exp 1", o_busy); end
    tbl_we = 1'b1; tbl_ctx = 1'b1; tbl_idx = 4'd0;
    tbl_addr = 32'h0BAD_0000; tbl_data = 32'h0BAD_0001;
    @(negedge clk);
    tbl_we = 1'b0;
    for (k = 0; k < 30 && o_busy; k++) @(negedge clk);
    n_vec++;
    if (o_busy !== 1'b0) begin n_bad++; $display("FAIL t6_wait got busy=%b exp 0", o_busy); end
    run_seq(0, 1, 3, 0, -1, 0, 100);
    build_exp(0, 1, 3, 0, -1);
    n_vec++;
    if (obs_q.size() !== 3 || r_ndone !== 1) begin
      n_bad++; $display("FAIL t6_replay got cnt=%0d n=%0d exp cnt=3 n=1", obs_q.size(), r_ndone);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL t6_txn%0d got %h exp %h", i, obs_q[i], exp_q[i]);
      end
    end
    load(1, 0, m_tab[1][0].addr, m_tab[1][0].data);
  endtask

  task automatic test_random();
    int s, c, l, g, bad;
    int gl[7] = '{0, 1, 2, 3, 4, TO - 1, TO};
    for (int it = 0; it < 40; it++) begin
      s = int'($urandom_range(0, 1));
      c = int'($urandom_range(0, 1));
      l = int'($urandom_range(0, 20));
      g = gl[$urandom_range(0, 6)];
      bad = (s == 1 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, NE - 1)) : -1;
      run_seq(s[0], c, l, g, bad, 0, 600);
      build_exp(s[0], c, l, g, bad);
      n_vec++;
      if (obs_q.size() !== exp_q.size() || r_hung || r_unst !== 0) begin
        n_bad++;
        $display("FAIL rnd%0d_count got %0d hung=%0d unst=%0d exp %0d", it, obs_q.size(), r_hung, r_unst, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rnd%0d_txn%0d got %h exp %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      n_vec++;
      if (r_err !== e_err || r_ndone !== int'(e_done) ||
          (e_err && r_eidx !== 4'(e_idx)) || (e_done && r_dcyc !== e_cyc)) begin
        n_bad++;
        $display("FAIL rnd%0d_end got err=%b idx=%0d n=%0d cyc=%0d exp err=%0d idx=%0d n=%0d cyc=%0d",
                 it, r_err, r_eidx, r_ndone, r_dcyc, e_err, e_idx, e_done, e_cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b1; tbl_we = 1'b0; tbl_ctx = '0; tbl_idx = '0;
    tbl_addr = '0; tbl_data = '0; sel = 1'b0; start = 1'b0;
    ctx = '0; len = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_load();
    test_t1_writes();
    test_t2_verify();
    test_t3_mismatch();
    test_err_clear();
    test_t4_timeout();
    test_gnt_vs_timeout();
    test_t5_len();
    test_t6_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
